mac_sequencer: RTL and testbench

Dot-product sequencer that sits directly upstream of the 8-bit Booth multiplier and also consumes its output. It accepts a command (base address, length), reads packed signed operand pairs from local memory, and drives the multiplier one pair at a time with a single-cycle start pulse. On each mul_done it accumulates the 16-bit signed product and returns the final sum through a valid/ready result handshake.

---
 rtl/pim_pkg.sv | 24 ++
 rtl/mac_accum.sv | 41 ++++
 rtl/mac_sequencer.sv | 165 ++++++++++++++++
 tb/tb_mac_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pim_pkg.sv
// Shared types and constants for the dot-product sequencer and its accumulator.
package pim_pkg;

   // Operand and product widths of the Booth multiplier interface
   localparam int unsigned OP_W   = 8;
   localparam int unsigned PROD_W = 16;

   // Field positions inside a packed operand word from local memory
   localparam int unsigned RDATA_W = 16;
   localparam int unsigned A_MSB   = 15;
   localparam int unsigned A_LSB   = 8;
   localparam int unsigned B_MSB   = 7;
   localparam int unsigned B_LSB   = 0;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StLatch,
      StStart,
      StWait,
      StDone
   } state_t;

endpackage

// File: rtl/mac_accum.sv
// Signed accumulator: synchronous clear, sign-extended add of a product, wraps at ACC_W.
module mac_accum
   import pim_pkg::*;
#(
   parameter int unsigned ACC_W = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              add_en,
   input  logic [PROD_W-1:0] addend,
   output logic [ACC_W-1:0]  acc
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] addend_ext;

   assign addend_ext = {{(ACC_W - PROD_W){addend[PROD_W-1]}}, addend};

   // Next accumulator value; clear wins over add
   always_comb begin
      acc_d = acc_q;
      if (clear) begin
         acc_d = '0;
      end else if (add_en) begin
         acc_d = acc_q + addend_ext;
      end
   end

   // Accumulator register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/mac_sequencer.sv
// Dot-product sequencer: fetches packed operand pairs, drives the Booth multiplier one
// pair at a time, accumulates products and returns the sum via a valid/ready handshake.
module mac_sequencer
   import pim_pkg::*;
#(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned LEN_W   = 8,
   parameter int unsigned ACC_W   = 24,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [ADDR_W-1:0]  cmd_base,
   input  logic [LEN_W-1:0]   cmd_len,
   output logic               mem_rd_en,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [RDATA_W-1:0] mem_rdata,
   output logic               mul_start,
   output logic [OP_W-1:0]    mul_a,
   output logic [OP_W-1:0]    mul_b,
   input  logic [PROD_W-1:0]  mul_product,
   input  logic               mul_done,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [ACC_W-1:0]   res_data,
   output logic               res_err
);

   localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
   // Watchdog value during the last allowed WAIT cycle
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  index_q, index_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              err_q, err_d;
   logic [OP_W-1:0]   a_q, a_d;
   logic [OP_W-1:0]   b_q, b_d;
   logic              acc_clear;
   logic              acc_add;
   logic              pair_end;
   logic [ACC_W-1:0]  acc;

   // Next-state and datapath control; every pair ends either on mul_done or on timeout
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      len_d     = len_q;
      index_d   = index_q;
      wd_d      = wd_q;
      err_d     = err_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_clear = 1'b0;
      acc_add   = 1'b0;
      pair_end  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               base_d    = cmd_base;
               len_d     = cmd_len;
               index_d   = '0;
               err_d     = 1'b0;
               acc_clear = 1'b1;
               state_d   = (cmd_len == '0) ? StDone : StFetch;
            end
         end
         StFetch: begin
            state_d = StLatch;
         end
         StLatch: begin
            a_d     = mem_rdata[A_MSB:A_LSB];
            b_d     = mem_rdata[B_MSB:B_LSB];
            state_d = StStart;
         end
         StStart: begin
            wd_d    = '0;
            state_d = StWait;
         end
         StWait: begin
            wd_d = wd_q + WD_W'(1);
            if (mul_done) begin
               acc_add  = 1'b1;
               pair_end = 1'b1;
            end else if (wd_q == WD_LAST) begin
               // Multiplier never answered: flag it and drop this pair
               err_d    = 1'b1;
               pair_end = 1'b1;
            end
            if (pair_end) begin
               index_d = index_q + LEN_W'(1);
               state_d = (index_q + LEN_W'(1) == len_q) ? StDone : StFetch;
            end
         end
         StDone: begin
            if (res_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Command, index, watchdog, error and operand registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base_q  <= '0;
         len_q   <= '0;
         index_q <= '0;
         wd_q    <= '0;
         err_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         base_q  <= base_d;
         len_q   <= len_d;
         index_q <= index_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

   mac_accum #(
      .ACC_W (ACC_W)
   ) u_accum (
      .clk    (clk),
      .reset  (reset),
      .clear  (acc_clear),
      .add_en (acc_add),
      .addend (mul_product),
      .acc    (acc)
   );

   // Outputs decoded from registered state; address wraps naturally at ADDR_W
   always_comb begin
      cmd_ready = (state_q == StIdle);
      mem_rd_en = (state_q == StFetch);
      mem_addr  = mem_rd_en ? (base_q + ADDR_W'(index_q)) : '0;
      mul_start = (state_q == StStart);
      mul_a     = a_q;
      mul_b     = b_q;
      res_valid = (state_q == StDone);
      res_data  = acc;
      res_err   = err_q;
   end

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer with memory and Booth multiplier models.
module tb_mac_sequencer;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_base;
   logic [7:0]  cmd_len;
   logic        mem_rd_en;
   logic [9:0]  mem_addr;
   logic [15:0] mem_rdata;
   logic        mul_start;
   logic [7:0]  mul_a;
   logic [7:0]  mul_b;
   logic [15:0] mul_product;
   logic        mul_done;
   logic        res_valid;
   logic        res_ready;
   logic [23:0] res_data;
   logic        res_err;

   int checks;
   int failures;

   mac_sequencer #(
      .ADDR_W  (10),
      .LEN_W   (8),
      .ACC_W   (24),
      .TIMEOUT (15)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_base    (cmd_base),
      .cmd_len     (cmd_len),
      .mem_rd_en   (mem_rd_en),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .mul_start   (mul_start),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_product (mul_product),
      .mul_done    (mul_done),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_err     (res_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: one-cycle read latency
   logic [15:0] mem [1024];
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
   end

   // Multiplier model: done 9 cycles after the start cycle; one pair may be withheld
   int          withhold_pair;
   int          pair_no;
   logic        m_busy;
   logic        m_skip;
   logic [3:0]  m_cnt;
   logic [15:0] m_prod;
   logic        inj_done;
   logic [15:0] inj_prod;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy  <= 1'b0;
         m_skip  <= 1'b0;
         m_cnt   <= 4'd0;
         m_prod  <= 16'd0;
         pair_no <= 0;
      end else begin
         if (cmd_valid && cmd_ready) pair_no <= 0;
         if (mul_start) begin
            m_busy  <= 1'b1;
            m_cnt   <= 4'd8;
            m_prod  <= $signed(mul_a) * $signed(mul_b);
            m_skip  <= (pair_no == withhold_pair);
            pair_no <= pair_no + 1;
         end else if (m_busy) begin
            if (m_cnt == 4'd0) m_busy <= 1'b0;
            else m_cnt <= m_cnt - 4'd1;
         end
      end
   end

   assign mul_done    = (m_busy && (m_cnt == 4'd0) && !m_skip) || inj_done;
   assign mul_product = inj_done ? inj_prod : m_prod;

   typedef struct {
      logic [9:0]       base;
      logic [7:0]       len;
      logic [3:0][15:0] w;
      int               withhold;
      logic [23:0]      exp_data;
      logic             exp_err;
      int               exp_cyc;
   } vec_t;

   vec_t vecs[5];

   function automatic vec_t mk(input logic [9:0] base, input logic [7:0] len,
                               input logic [15:0] w0, input logic [15:0] w1,
                               input logic [15:0] w2, input logic [15:0] w3,
                               input int wh, input logic [23:0] ed, input logic ee,
                               input int ec);
      vec_t v;
      v.base = base; v.len = len;
      v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
      v.withhold = wh; v.exp_data = ed; v.exp_err = ee; v.exp_cyc = ec;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue a command and follow it until res_valid; leaves the DUT in DONE at a negedge
   task automatic run_cmd(input vec_t v);
      int          nrd;
      int          nst;
      int          dbl;
      int          cyc;
      logic        prev;
      logic [9:0]  ea;
      for (int i = 0; i < int'(v.len); i++) begin
         ea = v.base + 10'(i);
         mem[ea] = v.w[i];
      end
      withhold_pair = v.withhold;
      nrd = 0; nst = 0; dbl = 0; cyc = 0; prev = 1'b0;
      @(negedge clk);
      chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_base  = v.base;
      cmd_len   = v.len;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         if (c == 1) cmd_valid = 1'b0;
         if (mem_rd_en) begin
            ea = v.base + 10'(nrd);
            chk("rd_addr", 32'(mem_addr), 32'(ea));
            nrd++;
         end
         if (mul_start) begin
            nst++;
            if (prev) dbl++;
         end
         prev = mul_start;
         if (res_valid) begin
            cyc = c;
            break;
         end
      end
      if (cyc == 0) begin
         checks++;
         failures++;
         $display("FAIL res_valid_timeout: got none expected cycle %0d", v.exp_cyc);
      end
      chk("valid_cycle", 32'(cyc), 32'(v.exp_cyc));
      chk("res_data", 32'(res_data), 32'(v.exp_data));
      chk("res_err", 32'(res_err), 32'(v.exp_err));
      chk("rd_count", 32'(nrd), 32'(v.len));
      chk("start_count", 32'(nst), 32'(v.len));
      chk("start_single_cycle", 32'(dbl), 32'd0);
   endtask

   // Accept the result and confirm the return to IDLE with held data
   task automatic release_res(input logic [23:0] exp_data, input logic exp_err);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("res_valid_drop", 32'(res_valid), 32'd0);
      chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
      chk("res_data_hold", 32'(res_data), 32'(exp_data));
      chk("res_err_hold", 32'(res_err), 32'(exp_err));
   endtask

   initial begin
      int nst;
      checks = 0; failures = 0;
      reset = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0; res_ready = 1'b0;
      inj_done = 1'b0; inj_prod = '0; withhold_pair = -1;
      for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;

      vecs[0] = mk(10'h010, 8'd1, 16'h0305, 16'h0, 16'h0, 16'h0, -1, 24'd15, 1'b0, 13);
      vecs[1] = mk(10'h3FE, 8'd4, 16'h7F7F, 16'h8080, 16'hFF02, 16'h0000, -1, 24'd32511,
                   1'b0, 49);
      vecs[2] = mk(10'h020, 8'd0, 16'h0, 16'h0, 16'h0, 16'h0, -1, 24'd0, 1'b0, 1);
      vecs[3] = mk(10'h100, 8'd3, 16'h0202, 16'h0202, 16'h0202, 16'h0, 1, 24'd8, 1'b1, 43);
      vecs[4] = mk(10'h200, 8'd2, 16'hFFFF, 16'h807F, 16'h0, 16'h0, -1, 24'hFFC081, 1'b0, 25);

      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_data", 32'(res_data), 32'd0);
      chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
      chk("rst_mul_start", 32'(mul_start), 32'd0);
      reset = 1'b0;

      for (int k = 0; k < 5; k++) begin
         run_cmd(vecs[k]);
         release_res(vecs[k].exp_data, vecs[k].exp_err);
      end

      // Late mul_done while in DONE must not disturb the result
      run_cmd(vecs[3]);
      inj_prod = 16'd100;
      inj_done = 1'b1;
      @(negedge clk);
      inj_done = 1'b0;
      chk("late_done_data", 32'(res_data), 32'd8);
      chk("late_done_valid", 32'(res_valid), 32'd1);
      release_res(24'd8, 1'b1);

      // Stall in DONE with res_ready low; a cmd_valid pulse there is ignored
      run_cmd(vecs[0]);
      for (int k = 0; k < 5; k++) begin
         chk("stall_valid", 32'(res_valid), 32'd1);
         chk("stall_data", 32'(res_data), 32'd15);
         chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
         if (k == 2) begin
            cmd_valid = 1'b1; cmd_len = 8'd0;
         end else begin
            cmd_valid = 1'b0;
         end
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      release_res(24'd15, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("no_queued_cmd", 32'(res_valid | mem_rd_en), 32'd0);
      end

      // Asynchronous reset in WAIT of pair 2, then a clean command
      for (int i = 0; i < 3; i++) mem[10'h100 + 10'(i)] = 16'h0202;
      withhold_pair = -1;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_base = 10'h100; cmd_len = 8'd3;
      nst = 0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         if (mul_start) nst++;
         if (nst == 2) break;
      end
      repeat (3) @(negedge clk);
      chk("pre_reset_acc", 32'(res_data), 32'd4);
      #2 reset = 1'b1;
      #1;
      chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("arst_mem_rd_en", 32'(mem_rd_en), 32'd0);
      chk("arst_mem_addr", 32'(mem_addr), 32'd0);
      chk("arst_mul_start", 32'(mul_start), 32'd0);
      chk("arst_mul_ab", 32'({mul_a, mul_b}), 32'd0);
      chk("arst_res_valid", 32'(res_valid), 32'd0);
      chk("arst_res_data", 32'(res_data), 32'd0);
      chk("arst_res_err", 32'(res_err), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_cmd(vecs[0]);
      release_res(24'd15, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
